// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-ported data memory: round-robin grant,
// per-port registered response, atomic lock, and alignment/mode rejection.
module dmem_arbiter #(
    parameter int DMEM_DATA_WIDTH = 32,
    parameter int DMEM_ADDR_WIDTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,

    input  logic                       req0_valid_i,
    output logic                       req0_ready_o,
    input  logic                       req0_we_i,
    input  logic [1:0]                 req0_mode_i,
    input  logic                       req0_lock_i,
    input  logic [DMEM_ADDR_WIDTH-1:0] req0_addr_i,
    input  logic [DMEM_DATA_WIDTH-1:0] req0_wdata_i,
    output logic                       rsp0_valid_o,
    input  logic                       rsp0_ready_i,
    output logic                       rsp0_err_o,
    output logic [DMEM_DATA_WIDTH-1:0] rsp0_rdata_o,

    input  logic                       req1_valid_i,
    output logic                       req1_ready_o,
    input  logic                       req1_we_i,
    input  logic [1:0]                 req1_mode_i,
    input  logic                       req1_lock_i,
    input  logic [DMEM_ADDR_WIDTH-1:0] req1_addr_i,
    input  logic [DMEM_DATA_WIDTH-1:0] req1_wdata_i,
    output logic                       rsp1_valid_o,
    input  logic                       rsp1_ready_i,
    output logic                       rsp1_err_o,
    output logic [DMEM_DATA_WIDTH-1:0] rsp1_rdata_o,

    output logic                       mem_wr_en_o,
    output logic [1:0]                 mem_rw_mode_o,
    output logic [DMEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DMEM_DATA_WIDTH-1:0] mem_w_data_o,
    input  logic [DMEM_DATA_WIDTH-1:0] mem_r_data_i
);
    localparam int DW = DMEM_DATA_WIDTH;
    localparam int AW = DMEM_ADDR_WIDTH;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED0  = 2'd1,
        LOCKED1  = 2'd2
    } lock_state_e;

    logic [1:0]         req_valid, req_we, req_lock, rsp_ready;
    logic [1:0][1:0]    req_mode;
    logic [1:0][AW-1:0] req_addr;
    logic [1:0][DW-1:0] req_wdata;

    assign req_valid = {req1_valid_i, req0_valid_i};
    assign req_we    = {req1_we_i,    req0_we_i};
    assign req_lock  = {req1_lock_i,  req0_lock_i};
    assign rsp_ready = {rsp1_ready_i, rsp0_ready_i};
    assign req_mode  = {req1_mode_i,  req0_mode_i};
    assign req_addr  = {req1_addr_i,  req0_addr_i};
    assign req_wdata = {req1_wdata_i, req0_wdata_i};

    lock_state_e        lock_q, lock_d;
    logic               last_q, last_d;
    logic [1:0]         rsp_valid_q, rsp_valid_d;
    logic [1:0]         rsp_err_q, rsp_err_d;
    logic [1:0][DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]         mem_mode_q, mem_mode_d;
    logic [AW-1:0]      mem_addr_q, mem_addr_d;
    logic [DW-1:0]      mem_wdata_q, mem_wdata_d;

    logic [1:0]    elig, grant;
    logic          any_grant, gsel;
    logic          g_we, g_lock, g_err;
    logic [1:0]    g_mode;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;

    // Nothing is granted while reset is asserted, so no write can start then.
    always_comb begin
        elig[0]   = rst_ni & req_valid[0] & (~rsp_valid_q[0] | rsp_ready[0]) & (lock_q != LOCKED1);
        elig[1]   = rst_ni & req_valid[1] & (~rsp_valid_q[1] | rsp_ready[1]) & (lock_q != LOCKED0);
        any_grant = |elig;
        gsel      = (elig == 2'b11) ? ~last_q : elig[1];
        grant     = 2'b00;
        if (any_grant) begin
            grant = gsel ? 2'b10 : 2'b01;
        end
    end

    assign g_we    = req_we[gsel];
    assign g_lock  = req_lock[gsel];
    assign g_mode  = req_mode[gsel];
    assign g_addr  = req_addr[gsel];
    assign g_wdata = req_wdata[gsel];

    assign g_err = (g_mode == 2'b11)
                 | ((g_mode == 2'b01) & g_addr[0])
                 | ((g_mode == 2'b00) & (g_addr[1:0] != 2'b00));

    assign mem_mode_d  = any_grant ? g_mode  : mem_mode_q;
    assign mem_addr_d  = any_grant ? g_addr  : mem_addr_q;
    assign mem_wdata_d = any_grant ? g_wdata : mem_wdata_q;

    assign mem_wr_en_o   = any_grant & g_we & ~g_err;
    assign mem_rw_mode_o = mem_mode_d;
    assign mem_addr_o    = mem_addr_d;
    assign mem_w_data_o  = mem_wdata_d;

    always_comb begin
        lock_d = lock_q;
        last_d = last_q;
        if (any_grant) begin
            last_d = gsel;
        end
        if (any_grant && !g_err) begin
            case (lock_q)
                UNLOCKED: if (g_lock)           lock_d = gsel ? LOCKED1 : LOCKED0;
                LOCKED0:  if (!gsel && !g_lock) lock_d = UNLOCKED;
                LOCKED1:  if (gsel && !g_lock)  lock_d = UNLOCKED;
                default:                        lock_d = UNLOCKED;
            endcase
        end
    end

    // A new grant reloads the slot even if the old response drains on the same edge.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        for (int p = 0; p < 2; p++) begin
            if (grant[p]) begin
                rsp_valid_d[p] = 1'b1;
                rsp_err_d[p]   = g_err;
                rsp_rdata_d[p] = (g_we || g_err) ? '0 : mem_r_data_i;
            end else if (rsp_ready[p]) begin
                rsp_valid_d[p] = 1'b0;
                rsp_err_d[p]   = 1'b0;
                rsp_rdata_d[p] = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q      <= UNLOCKED;
            last_q      <= 1'b1;
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            rsp_rdata_q <= '0;
            mem_mode_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            lock_q      <= lock_d;
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_mode_q  <= mem_mode_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign req0_ready_o = grant[0];
    assign req1_ready_o = grant[1];
    assign rsp0_valid_o = rsp_valid_q[0];
    assign rsp1_valid_o = rsp_valid_q[1];
    assign rsp0_err_o   = rsp_err_q[0];
    assign rsp1_err_o   = rsp_err_q[1];
    assign rsp0_rdata_o = rsp_rdata_q[0];
    assign rsp1_rdata_o = rsp_rdata_q[1];

endmodule
